// File: rtl/collision_tracker_pkg.sv
// Shared definitions for the collision tracker: state encodings, widths and defaults.
package collision_tracker_pkg;

   localparam int unsigned STATE_W = 2;
   localparam int unsigned OVL_W   = 4;
   localparam int unsigned INV_W   = 8;
   localparam int unsigned LIVES_W = 2;

   localparam logic [STATE_W-1:0] ST_PLAY   = 2'd0;
   localparam logic [STATE_W-1:0] ST_INVULN = 2'd1;
   localparam logic [STATE_W-1:0] ST_OVER   = 2'd2;

   localparam int unsigned LIVES_INIT_DEF    = 3;
   localparam int unsigned INVULN_FRAMES_DEF = 90;
   localparam int unsigned MIN_OVERLAP_DEF   = 4;
   localparam int unsigned SCORE_W_DEF       = 16;

   // Saturating increment for the per-frame overlap count.
   function automatic logic [OVL_W-1:0] ovl_sat_inc(input logic [OVL_W-1:0] v);
      return (v == {OVL_W{1'b1}}) ? v : v + OVL_W'(1);
   endfunction

endpackage

// File: rtl/frame_overlap_counter.sv
// Counts meteor/player overlap pixels within the current frame, saturating.
module frame_overlap_counter
   import collision_tracker_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_start,
   input  logic             hit_px,
   output logic [OVL_W-1:0] ovl_cnt
);

   // The frame_start pixel already belongs to the new frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovl_cnt <= '0;
      end else if (frame_start) begin
         ovl_cnt <= OVL_W'(hit_px);
      end else if (hit_px) begin
         ovl_cnt <= ovl_sat_inc(ovl_cnt);
      end
   end

endmodule

// File: rtl/collision_tracker.sv
// Per-frame hit decision, lives, invulnerability window, survival score and game over.
module collision_tracker
   import collision_tracker_pkg::*;
#(
   parameter int unsigned LIVES_INIT    = LIVES_INIT_DEF,
   parameter int unsigned INVULN_FRAMES = INVULN_FRAMES_DEF,
   parameter int unsigned MIN_OVERLAP   = MIN_OVERLAP_DEF,
   parameter int unsigned SCORE_W       = SCORE_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_start,
   input  logic               video_active,
   input  logic               meteor_on,
   input  logic               player_on,
   input  logic               restart,
   output logic [LIVES_W-1:0] lives,
   output logic               game_over,
   output logic               invuln,
   output logic               hit_flash,
   output logic               collision_pulse,
   output logic [SCORE_W-1:0] score
);

   logic               hit_px_c;
   logic [OVL_W-1:0]   ovl_cnt;
   logic               frame_hit_c;
   logic               restart_q;
   logic               rst_req;
   logic               rst_req_next;
   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_next;
   logic [LIVES_W-1:0] lives_next;
   logic [INV_W-1:0]   inv_cnt;
   logic [INV_W-1:0]   inv_cnt_next;
   logic [SCORE_W-1:0] score_next;
   logic               pulse_next;

   assign hit_px_c    = video_active & meteor_on & player_on;
   assign frame_hit_c = (ovl_cnt >= OVL_W'(MIN_OVERLAP));

   frame_overlap_counter u_ovl (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .hit_px      (hit_px_c),
      .ovl_cnt     (ovl_cnt)
   );

   // A restart edge arriving on a frame_start cycle waits for the following frame.
   assign rst_req_next = (restart & ~restart_q) | (rst_req & ~frame_start);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         restart_q <= 1'b0;
         rst_req   <= 1'b0;
      end else begin
         restart_q <= restart;
         rst_req   <= rst_req_next;
      end
   end

   // Next-state logic: everything game-related moves only on frame_start.
   always_comb begin
      state_next   = state;
      lives_next   = lives;
      inv_cnt_next = inv_cnt;
      score_next   = score;
      pulse_next   = 1'b0;
      if (frame_start) begin
         if (rst_req) begin
            state_next   = ST_PLAY;
            lives_next   = LIVES_W'(LIVES_INIT);
            inv_cnt_next = '0;
            score_next   = '0;
         end else begin
            if ((state != ST_OVER) && (score != {SCORE_W{1'b1}})) begin
               score_next = score + SCORE_W'(1);
            end
            case (state)
               ST_PLAY: begin
                  if (frame_hit_c) begin
                     pulse_next = 1'b1;
                     if (lives <= LIVES_W'(1)) begin
                        state_next = ST_OVER;
                        lives_next = '0;
                     end else begin
                        state_next   = ST_INVULN;
                        lives_next   = lives - LIVES_W'(1);
                        inv_cnt_next = INV_W'(INVULN_FRAMES);
                     end
                  end
               end
               ST_INVULN: begin
                  if (inv_cnt <= INV_W'(1)) begin
                     state_next   = ST_PLAY;
                     inv_cnt_next = '0;
                  end else begin
                     inv_cnt_next = inv_cnt - INV_W'(1);
                  end
               end
               ST_OVER: begin
                  state_next = ST_OVER;
               end
               default: begin
                  state_next   = ST_PLAY;
                  inv_cnt_next = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= ST_PLAY;
         lives           <= LIVES_W'(LIVES_INIT);
         inv_cnt         <= '0;
         score           <= '0;
         collision_pulse <= 1'b0;
         game_over       <= 1'b0;
         invuln          <= 1'b0;
         hit_flash       <= 1'b0;
      end else begin
         state           <= state_next;
         lives           <= lives_next;
         inv_cnt         <= inv_cnt_next;
         score           <= score_next;
         collision_pulse <= pulse_next;
         game_over       <= (state_next == ST_OVER);
         invuln          <= (state_next == ST_INVULN);
         hit_flash       <= (state_next == ST_INVULN) & inv_cnt_next[3];
      end
   end

endmodule

// File: tb/tb_collision_tracker.sv
// Randomized frame stimulus for collision_tracker checked against a frame-level game model.
module tb_collision_tracker;

   localparam int LIVES0    = 3;
   localparam int INV_FR    = 90;
   localparam int MIN_OVL   = 4;
   localparam int SCORE_MAX = 65535;

   logic        clk;
   logic        reset;
   logic        frame_start;
   logic        video_active;
   logic        meteor_on;
   logic        player_on;
   logic        restart;
   logic [1:0]  lives;
   logic        game_over;
   logic        invuln;
   logic        hit_flash;
   logic        collision_pulse;
   logic [15:0] score;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pulses = 0;

   // Reference model state: plain integers describing the game, not the hardware.
   int m_lives;
   int m_inv_left;
   int m_score;
   int m_pix;
   bit m_over;
   bit m_pulse;
   bit m_pending;
   bit m_prev_rs;

   collision_tracker dut (
      .clk             (clk),
      .reset           (reset),
      .frame_start     (frame_start),
      .video_active    (video_active),
      .meteor_on       (meteor_on),
      .player_on       (player_on),
      .restart         (restart),
      .lives           (lives),
      .game_over       (game_over),
      .invuln          (invuln),
      .hit_flash       (hit_flash),
      .collision_pulse (collision_pulse),
      .score           (score)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_lives    = LIVES0;
      m_inv_left = 0;
      m_score    = 0;
      m_pix      = 0;
      m_over     = 1'b0;
      m_pulse    = 1'b0;
      m_pending  = 1'b0;
      m_prev_rs  = 1'b0;
   endtask

   task automatic model_step(input bit fs, input bit hp, input bit rs);
      bit rs_edge;
      bit hit;
      rs_edge = rs && !m_prev_rs;
      m_pulse = 1'b0;
      if (fs) begin
         hit = (m_pix >= MIN_OVL);
         if (m_pending) begin
            m_lives    = LIVES0;
            m_over     = 1'b0;
            m_inv_left = 0;
            m_score    = 0;
         end else if (!m_over) begin
            if (m_score < SCORE_MAX) m_score++;
            if (m_inv_left > 0) begin
               m_inv_left--;
            end else if (hit) begin
               m_pulse = 1'b1;
               m_lives--;
               if (m_lives == 0) m_over = 1'b1;
               else m_inv_left = INV_FR;
            end
         end
         m_pending = 1'b0;
         m_pix     = hp ? 1 : 0;
      end else begin
         m_pix += hp ? 1 : 0;
      end
      if (rs_edge) m_pending = 1'b1;
      m_prev_rs = rs;
   endtask

   task automatic compare_outputs();
      check_eq("lives", int'(lives), m_lives);
      check_eq("game_over", int'(game_over), int'(m_over));
      check_eq("invuln", int'(invuln), (m_inv_left > 0) ? 1 : 0);
      check_eq("hit_flash", int'(hit_flash), ((m_inv_left > 0) && (((m_inv_left >> 3) & 1) == 1)) ? 1 : 0);
      check_eq("collision_pulse", int'(collision_pulse), int'(m_pulse));
      check_eq("score", int'(score), m_score);
   endtask

   task automatic drive_cycle(input bit fs, input bit va, input bit mo, input bit po, input bit rs);
      frame_start  = fs;
      video_active = va;
      meteor_on    = mo;
      player_on    = po;
      restart      = rs;
      @(posedge clk);
      model_step(fs, va & mo & po, rs);
      #1;
      compare_outputs();
      if (collision_pulse) n_pulses++;
   endtask

   // One frame: nhit overlap pixels at a random offset, random non-overlapping noise elsewhere.
   task automatic run_frame(input int len, input int nhit, input bit start_hit, input bit do_restart);
      int off;
      bit va, mo, po, h;
      off = (nhit > 0) ? int'($urandom_range(len - nhit, 1)) : 1;
      for (int c = 0; c < len; c++) begin
         h  = (c == 0) ? start_hit : ((c >= off) && (c < off + nhit));
         va = 1'($urandom);
         mo = 1'($urandom);
         po = 1'($urandom);
         if (h) begin
            va = 1'b1; mo = 1'b1; po = 1'b1;
         end else if (va && mo && po) begin
            if ($urandom_range(2, 0) == 0) va = 1'b0;
            else if ($urandom_range(1, 0) == 0) mo = 1'b0;
            else po = 1'b0;
         end
         drive_cycle(c == 0, va, mo, po, do_restart && (c == 2 || c == 3));
      end
   endtask

   initial begin
      int saved_score;
      frame_start = 0; video_active = 0; meteor_on = 0; player_on = 0; restart = 0;
      reset = 1'b1;
      model_reset();
      #1;
      check_eq("rst_lives", int'(lives), 3);
      check_eq("rst_score", int'(score), 0);
      check_eq("rst_game_over", int'(game_over), 0);
      check_eq("rst_invuln", int'(invuln), 0);
      check_eq("rst_pulse", int'(collision_pulse), 0);
      repeat (2) @(posedge clk);
      #4 reset = 1'b0;
      #2;

      // Below threshold, then exactly at threshold
      run_frame(20, 3, 1'b0, 1'b0);
      run_frame(20, 4, 1'b0, 1'b0);
      check_eq("t1_lives", int'(lives), 3);
      check_eq("t1_pulses", n_pulses, 0);
      check_eq("t1_score", int'(score), 2);
      run_frame(20, 5, 1'b0, 1'b0);
      check_eq("t2_lives", int'(lives), 2);
      check_eq("t2_invuln", int'(invuln), 1);
      check_eq("t2_pulses", n_pulses, 1);

      // Overlap every frame while invulnerable
      repeat (89) run_frame(16, 5, 1'b0, 1'b0);
      check_eq("t3_still_invuln", int'(invuln), 1);
      check_eq("t3_pulses", n_pulses, 1);
      run_frame(16, 5, 1'b0, 1'b0);
      check_eq("t3_back_to_play", int'(invuln), 0);
      check_eq("t3_lives", int'(lives), 2);
      run_frame(16, 0, 1'b0, 1'b0);
      check_eq("t3_second_hit", int'(lives), 1);
      check_eq("t3_pulses2", n_pulses, 2);

      // Third hit ends the game; score freezes
      repeat (89) run_frame(12, 0, 1'b0, 1'b0);
      check_eq("t4_invuln", int'(invuln), 1);
      run_frame(12, 4, 1'b0, 1'b0);
      check_eq("t4_play", int'(invuln), 0);
      run_frame(12, 0, 1'b0, 1'b0);
      check_eq("t4_game_over", int'(game_over), 1);
      check_eq("t4_lives", int'(lives), 0);
      check_eq("t4_pulses", n_pulses, 3);
      saved_score = m_score;
      repeat (10) run_frame(12, 6, 1'b0, 1'b0);
      check_eq("t4_score_frozen", int'(score), saved_score);
      check_eq("t4_pulses_frozen", n_pulses, 3);

      // Restart with heavy overlap in the same frame
      run_frame(30, 20, 1'b0, 1'b1);
      run_frame(12, 0, 1'b0, 1'b0);
      check_eq("t5_lives", int'(lives), 3);
      check_eq("t5_score", int'(score), 0);
      check_eq("t5_game_over", int'(game_over), 0);
      run_frame(12, 0, 1'b0, 1'b0);
      check_eq("t5_no_hit", n_pulses, 3);
      check_eq("t5_score_runs", int'(score), 1);

      // Overlap on the frame_start pixel counts toward the new frame
      run_frame(12, 3, 1'b1, 1'b0);
      run_frame(12, 0, 1'b0, 1'b0);
      check_eq("t6_lives", int'(lives), 2);
      check_eq("t6_pulses", n_pulses, 4);

      // Asynchronous reset mid-frame, partial frame evaluated afterwards
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      reset = 1'b1;
      #1;
      model_reset();
      check_eq("t6_rst_lives", int'(lives), 3);
      check_eq("t6_rst_score", int'(score), 0);
      check_eq("t6_rst_invuln", int'(invuln), 0);
      check_eq("t6_rst_flash", int'(hit_flash), 0);
      check_eq("t6_rst_over", int'(game_over), 0);
      #3 reset = 1'b0;
      repeat (4) drive_cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      run_frame(12, 0, 1'b0, 1'b0);
      check_eq("t6_partial_hit", int'(lives), 2);
      check_eq("t6_partial_pulse", n_pulses, 5);

      // Randomized frames against the model
      repeat (150) begin
         run_frame(int'($urandom_range(24, 12)), int'($urandom_range(7, 0)),
                   1'($urandom), ($urandom_range(7, 0) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
